// File: rtl/traffic_pkg.sv
// -----------------------------------------------------------------------------
// traffic_pkg
// Shared types and constants for the highway / farm-road traffic light
// controller.
//   state_t          : FSM state encoding (3-bit, 6 legal encodings)
//   Def*             : default phase durations in clock cycles
//   max_u()          : elaboration-time helper for sizing the phase timer
//   state_lamps()    : state -> lamp vector {hr,hy,hg,fr,fy,fg}
// -----------------------------------------------------------------------------
package traffic_pkg;

  typedef enum logic [2:0] {
    StHwyGreen  = 3'd0,
    StHwyYellow = 3'd1,
    StAllRedA   = 3'd2,
    StFarmGreen = 3'd3,
    StFarmYellow = 3'd4,
    StAllRedB   = 3'd5
  } state_t;

  localparam int unsigned DefHwyGreen   = 8;
  localparam int unsigned DefHwyYellow  = 3;
  localparam int unsigned DefFarmGreen  = 5;
  localparam int unsigned DefFarmYellow = 3;
  localparam int unsigned DefAllRed     = 1;

  // Lamp vectors, ordered {hr,hy,hg,fr,fy,fg}.
  localparam logic [5:0] LampHwyGreen   = 6'b001_100;
  localparam logic [5:0] LampHwyYellow  = 6'b010_100;
  localparam logic [5:0] LampAllRed     = 6'b100_100;
  localparam logic [5:0] LampFarmGreen  = 6'b100_001;
  localparam logic [5:0] LampFarmYellow = 6'b100_010;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

  function automatic logic [5:0] state_lamps(input state_t s);
    logic [5:0] lamps;
    case (s)
      StHwyGreen:   lamps = LampHwyGreen;
      StHwyYellow:  lamps = LampHwyYellow;
      StAllRedA:    lamps = LampAllRed;
      StFarmGreen:  lamps = LampFarmGreen;
      StFarmYellow: lamps = LampFarmYellow;
      StAllRedB:    lamps = LampAllRed;
      // Illegal encodings show all-red for the single cycle before recovery.
      default:      lamps = LampAllRed;
    endcase
    return lamps;
  endfunction

endpackage

// File: rtl/phase_timer.sv
// -----------------------------------------------------------------------------
// phase_timer
// Free-running phase counter. Counts up from 0 each clock; done flags the last
// cycle of the current phase (count == load-1). The owner clears it on phase
// change.
// Ports:
//   clk    in   rising-edge clock
//   reset  in   synchronous active-high reset, count <= 0
//   clear  in   synchronous clear, count <= 0
//   load   in   current phase duration in cycles (>=1), WIDTH+1 bits
//   done   out  count == load-1
// -----------------------------------------------------------------------------
module phase_timer #(
  parameter int unsigned WIDTH = 3
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           clear,
  input  logic [WIDTH:0] load,
  output logic           done
);

  logic [WIDTH-1:0] r_count;
  logic [WIDTH:0]   w_last;

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      r_count <= '0;
    end else begin
      r_count <= r_count + 1'b1;
    end
  end

  assign w_last = load - (WIDTH + 1)'(1);
  assign done   = ({1'b0, r_count} == w_last);

endmodule

// File: rtl/traffic_light_controller.sv
// -----------------------------------------------------------------------------
// traffic_light_controller
// Fixed-time two-road sequencer:
//   HWY_GREEN -> HWY_YELLOW -> ALL_RED_A -> FARM_GREEN -> FARM_YELLOW
//   -> ALL_RED_B -> HWY_GREEN
// Each state lasts its *_CYCLES parameter. Moore outputs decoded from the
// registered state only.
// Ports:
//   clk             in   rising-edge clock
//   reset           in   synchronous active-high reset -> HWY_GREEN, timer 0
//   highway_red     out  highway red lamp
//   highway_yellow  out  highway yellow lamp
//   highway_green   out  highway green lamp
//   farm_red        out  farm-road red lamp
//   farm_yellow     out  farm-road yellow lamp
//   farm_green      out  farm-road green lamp
// -----------------------------------------------------------------------------
module traffic_light_controller
  import traffic_pkg::*;
#(
  parameter int unsigned HWY_GREEN_CYCLES   = DefHwyGreen,
  parameter int unsigned HWY_YELLOW_CYCLES  = DefHwyYellow,
  parameter int unsigned FARM_GREEN_CYCLES  = DefFarmGreen,
  parameter int unsigned FARM_YELLOW_CYCLES = DefFarmYellow,
  parameter int unsigned ALL_RED_CYCLES     = DefAllRed
) (
  input  logic clk,
  input  logic reset,
  output logic highway_red,
  output logic highway_yellow,
  output logic highway_green,
  output logic farm_red,
  output logic farm_yellow,
  output logic farm_green
);

  localparam int unsigned MaxDur = max_u(max_u(max_u(HWY_GREEN_CYCLES, HWY_YELLOW_CYCLES),
                                               max_u(FARM_GREEN_CYCLES, FARM_YELLOW_CYCLES)),
                                         ALL_RED_CYCLES);
  localparam int unsigned TimerW = (MaxDur > 1) ? $clog2(MaxDur) : 1;
  // One extra bit so the duration itself (not just duration-1) is representable.
  localparam int unsigned LoadW  = TimerW + 1;

  state_t           r_state;
  state_t           w_state_next;
  logic             w_done;
  logic             w_illegal;
  logic             w_clear;
  logic [LoadW-1:0] w_load;
  logic [5:0]       w_lamps;

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= StHwyGreen;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic.
  always_comb begin
    w_state_next = r_state;
    w_illegal    = 1'b0;
    case (r_state)
      StHwyGreen:   if (w_done) w_state_next = StHwyYellow;
      StHwyYellow:  if (w_done) w_state_next = StAllRedA;
      StAllRedA:    if (w_done) w_state_next = StFarmGreen;
      StFarmGreen:  if (w_done) w_state_next = StFarmYellow;
      StFarmYellow: if (w_done) w_state_next = StAllRedB;
      StAllRedB:    if (w_done) w_state_next = StHwyGreen;
      default: begin
        w_state_next = StHwyGreen;
        w_illegal    = 1'b1;
      end
    endcase
  end

  // Duration of the current phase.
  always_comb begin
    case (r_state)
      StHwyGreen:   w_load = LoadW'(HWY_GREEN_CYCLES);
      StHwyYellow:  w_load = LoadW'(HWY_YELLOW_CYCLES);
      StAllRedA:    w_load = LoadW'(ALL_RED_CYCLES);
      StFarmGreen:  w_load = LoadW'(FARM_GREEN_CYCLES);
      StFarmYellow: w_load = LoadW'(FARM_YELLOW_CYCLES);
      StAllRedB:    w_load = LoadW'(ALL_RED_CYCLES);
      default:      w_load = LoadW'(HWY_GREEN_CYCLES);
    endcase
  end

  // Timer restarts whenever the state changes, including illegal-state recovery.
  assign w_clear = w_done | w_illegal;

  phase_timer #(
    .WIDTH (TimerW)
  ) u_phase_timer (
    .clk   (clk),
    .reset (reset),
    .clear (w_clear),
    .load  (w_load),
    .done  (w_done)
  );

  // Output decode.
  always_comb begin
    w_lamps        = state_lamps(r_state);
    highway_red    = w_lamps[5];
    highway_yellow = w_lamps[4];
    highway_green  = w_lamps[3];
    farm_red       = w_lamps[2];
    farm_yellow    = w_lamps[1];
    farm_green     = w_lamps[0];
  end

endmodule

// File: tb/tb_traffic_light_controller.sv
module tb_traffic_light_controller;

  // Lamp vectors {hr,hy,hg,fr,fy,fg}, written out independently of the DUT package.
  localparam logic [5:0] HG = 6'b001_100;
  localparam logic [5:0] HY = 6'b010_100;
  localparam logic [5:0] AR = 6'b100_100;
  localparam logic [5:0] FG = 6'b100_001;
  localparam logic [5:0] FY = 6'b100_010;

  logic clk = 1'b0;
  logic reset = 1'b1;

  logic d_hr, d_hy, d_hg, d_fr, d_fy, d_fg;
  logic s_hr, s_hy, s_hg, s_fr, s_fy, s_fg;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  traffic_light_controller dut_def (
    .clk            (clk),
    .reset          (reset),
    .highway_red    (d_hr),
    .highway_yellow (d_hy),
    .highway_green  (d_hg),
    .farm_red       (d_fr),
    .farm_yellow    (d_fy),
    .farm_green     (d_fg)
  );

  traffic_light_controller #(
    .HWY_GREEN_CYCLES   (1),
    .HWY_YELLOW_CYCLES  (1),
    .FARM_GREEN_CYCLES  (1),
    .FARM_YELLOW_CYCLES (1),
    .ALL_RED_CYCLES     (2)
  ) dut_small (
    .clk            (clk),
    .reset          (reset),
    .highway_red    (s_hr),
    .highway_yellow (s_hy),
    .highway_green  (s_hg),
    .farm_red       (s_fr),
    .farm_yellow    (s_fy),
    .farm_green     (s_fg)
  );

  wire [5:0] lamps_def   = {d_hr, d_hy, d_hg, d_fr, d_fy, d_fg};
  wire [5:0] lamps_small = {s_hr, s_hy, s_hg, s_fr, s_fy, s_fg};

  // Expected lamps k cycles after the last reset edge, default timing (period 21).
  function automatic logic [5:0] exp_def(input int k);
    int p;
    p = k % 21;
    if (p < 8)       return HG;
    else if (p < 11) return HY;
    else if (p < 12) return AR;
    else if (p < 17) return FG;
    else if (p < 20) return FY;
    else             return AR;
  endfunction

  // Override timing 1/1/2/1/1/2 (period 8).
  function automatic logic [5:0] exp_small(input int k);
    int p;
    p = k % 8;
    case (p)
      0:       return HG;
      1:       return HY;
      2, 3:    return AR;
      4:       return FG;
      5:       return FY;
      default: return AR;
    endcase
  endfunction

  task automatic chk(input string name, input int idx, input logic [5:0] act,
                     input logic [5:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s[%0d]: got %b expected %b", name, idx, act, exp);
    end
  endtask

  task automatic chk_inv(input int idx, input logic [5:0] v);
    logic ok;
    ok = ($countones(v[5:3]) == 1) && ($countones(v[2:0]) == 1) &&
         !(!v[5] && !v[2]);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL invariant[%0d]: got %b expected one-hot per road, one road red", idx, v);
    end
  endtask

  // Apply reset value for one edge, then settle before sampling.
  task automatic step(input logic r);
    reset = r;
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic       rst;
    logic [5:0] exp_d;
    logic [5:0] exp_s;
  } vec_t;

  vec_t vecs[$];

  initial begin
    int k;
    int md;
    int ms;

    // Reset for two edges, then one full default period plus wrap.
    vecs.push_back('{1'b1, HG, HG});
    vecs.push_back('{1'b1, HG, HG});
    for (int i = 1; i <= 44; i++) begin
      vecs.push_back('{1'b0, exp_def(i), exp_small(i)});
    end

    #1;
    foreach (vecs[i]) begin
      step(vecs[i].rst);
      chk("vec_def", i, lamps_def, vecs[i].exp_d);
      chk("vec_small", i, lamps_small, vecs[i].exp_s);
    end

    // Reset held for 30 cycles: no change.
    for (int i = 0; i < 30; i++) begin
      step(1'b1);
      chk("hold_reset", i, lamps_def, HG);
    end

    // Run to cycle 14 (farm green), then a single reset edge.
    for (k = 1; k <= 14; k++) step(1'b0);
    chk("mid_pre_fg", 14, lamps_def, FG);
    step(1'b1);
    chk("mid_reset", 0, lamps_def, HG);
    for (k = 1; k <= 8; k++) begin
      step(1'b0);
      chk("mid_after", k, lamps_def, (k < 8) ? HG : HY);
    end

    // Repeated pulses: high, low, high, then low; timing restarts at final edge.
    for (k = 1; k <= 5; k++) step(1'b0);
    step(1'b1);
    chk("pulse_a", 0, lamps_def, HG);
    step(1'b0);
    chk("pulse_gap", 1, lamps_def, HG);
    step(1'b1);
    chk("pulse_b", 0, lamps_def, HG);
    for (k = 1; k <= 9; k++) begin
      step(1'b0);
      chk("pulse_after", k, lamps_def, exp_def(k));
    end

    // 200 cycles with random reset pulses, tracked by a cycle model.
    step(1'b1);
    md = 0;
    ms = 0;
    for (int i = 0; i < 200; i++) begin
      logic r;
      r = ($urandom_range(0, 15) == 0);
      step(r);
      if (r) begin
        md = 0;
        ms = 0;
      end else begin
        md = (md + 1) % 21;
        ms = (ms + 1) % 8;
      end
      chk_inv(i, lamps_def);
      chk_inv(i, lamps_small);
      chk("rand_def", i, lamps_def, exp_def(md));
      chk("rand_small", i, lamps_small, exp_small(ms));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/traffic_light_controller.md
Name: traffic_light_controller

Overview:
- Two-road traffic light sequencer for a highway / farm-road intersection.
- Runs a fixed-time cycle: the highway green phase, then a clearance phase, then the farm green phase, then back. No vehicle sensor.
- Moore FSM plus a phase-duration timer.
- Top-level leaf block; drives six lamp outputs directly.

Parameters:
- HWY_GREEN_CYCLES, 8, clock cycles in HWY_GREEN (>=1)
- HWY_YELLOW_CYCLES, 3, clock cycles in HWY_YELLOW (>=1)
- FARM_GREEN_CYCLES, 5, clock cycles in FARM_GREEN (>=1)
- FARM_YELLOW_CYCLES, 3, clock cycles in FARM_YELLOW (>=1)
- ALL_RED_CYCLES, 1, clock cycles in each all-red clearance state (>=1)

Ports:
- clk  input  1  system clock, rising-edge
- reset  input  1  synchronous, active-high reset
- highway_red  output  1  highway red lamp
- highway_yellow  output  1  highway yellow lamp
- highway_green  output  1  highway green lamp
- farm_red  output  1  farm-road red lamp
- farm_yellow  output  1  farm-road yellow lamp
- farm_green  output  1  farm-road green lamp

Behaviour:
- Clocking and reset:
  - One clock.
  - Reset is synchronous and active-high.
  - A rising edge with reset=1 forces state=HWY_GREEN and timer=0.
- Reset output values, valid from the first edge sampling reset=1:
  - highway_green=1, highway_yellow=0, highway_red=0
  - farm_red=1, farm_yellow=0, farm_green=0
- States, in order: HWY_GREEN -> HWY_YELLOW -> ALL_RED_A -> FARM_GREEN -> FARM_YELLOW -> ALL_RED_B -> HWY_GREEN.
- Timer:
  - Cleared to 0 on state entry; increments by 1 each clock.
  - When timer == duration-1, the next edge advances the state and clears the timer.
  - Each state therefore persists exactly its parameter's number of cycles.
  - Timer width is $clog2 of the largest duration, minimum 1 bit.
- Default full period is 8+3+1+5+3+1 = 21 cycles.
- Output decode (Moore, purely from the registered state):
  - HWY_GREEN: highway green, farm red
  - HWY_YELLOW: highway yellow, farm red
  - ALL_RED_A / ALL_RED_B: both roads red
  - FARM_GREEN: highway red, farm green
  - FARM_YELLOW: highway red, farm yellow
- Invariants, all cycles:
  - Exactly one lamp per road is on (one-hot per road).
  - Never a non-red lamp on both roads at once.
- Reset mid-cycle: from any state or timer value, the next edge with reset=1 gives HWY_GREEN with timer=0.
- Holding reset high keeps HWY_GREEN indefinitely.
- After release, HWY_GREEN lasts the full HWY_GREEN_CYCLES counted from the last reset edge.
- Illegal or unreachable state encodings return to HWY_GREEN on the next edge, timer=0.
- Outputs come from registered state through decode only; no combinational path from reset to outputs.

Decomposition:
- Package traffic_pkg holds:
  - the state enum (6 encodings, 3-bit)
  - default duration constants
  - a function mapping state to the 6-bit lamp vector {hr,hy,hg,fr,fy,fg}
- Sub-module phase_timer: a parameterised counter with inputs clk, reset and clear, and output done (asserted when count == load-1). The phase duration is selected by the FSM per state.
- The FSM, the duration mux and the decode stay in the top.

Test Plan:
- Reset: reset=1 for 2 edges -> highway_green=1, farm_red=1, all other lamps 0. Holding reset for 30 cycles produces no change.
- Full cycle with defaults, counting cycles after the reset-release edge:
  - cycles 0-7 highway green
  - 8-10 highway yellow
  - 11 all red
  - 12-16 farm green
  - 17-19 farm yellow
  - 20 all red
  - 21 highway green again
- Mid-operation reset: assert reset for 1 edge at cycle 14 (FARM_GREEN) -> next cycle highway_green=1, farm_red=1, and highway green then holds 8 cycles.
- Repeated reset pulses: 1 high, 1 low, 1 high, then low -> highway green held for 8 cycles counted from the final reset edge; no glitch to yellow.
- Invariant check across 200 cycles, including random reset pulses -> each road one-hot, never green/yellow on both roads.
- Parameter override HWY_GREEN=1, HWY_YELLOW=1, FARM_GREEN=1, FARM_YELLOW=1, ALL_RED=2 -> period 8 cycles, each all-red state lasting 2 cycles.
